// File: rtl/vic_scandoubler.sv
// rtl/vic_scandoubler.sv - VIC-II line doubler: ping-pong line buffer, 2x replay, C64 palette
module vic_scandoubler #(
  parameter  int LINE_MAX = 512,
  parameter  int IN_DIV   = 8,
  parameter  int HS_WIDTH = 48,
  localparam int ADDR_W   = $clog2(LINE_MAX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_ce,
  input  logic [3:0]        in_color,
  input  logic              in_hsync,
  input  logic              in_vsync,
  output logic              out_ce,
  output logic [11:0]       out_rgb,
  output logic              out_hsync,
  output logic              out_vsync,
  output logic              out_de,
  output logic [ADDR_W:0]   line_len,
  output logic              overflow
);

  localparam int                HALF     = IN_DIV / 2;
  localparam int                DIV_W    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(HALF - 1);
  localparam logic [ADDR_W:0]   LMAX     = (ADDR_W + 1)'(LINE_MAX);
  localparam logic [ADDR_W:0]   HS_W     = (ADDR_W + 1)'(HS_WIDTH);

  logic [3:0]        mem [0:2*LINE_MAX-1];
  logic              hs_prev;
  logic              hs_rise;
  logic              wr_bank;
  logic [ADDR_W:0]   wr_x;
  logic              we;
  logic [ADDR_W:0]   wr_addr;
  logic [ADDR_W:0]   rd_addr;
  logic [DIV_W-1:0]  div;
  logic              out_tick;
  logic [ADDR_W:0]   rd_x;
  logic [ADDR_W:0]   rd_len;
  logic              vs_line;
  logic              synced;
  logic [3:0]        rd_data;
  logic              s1_ce;
  logic              s1_de;
  logic              s1_hs;
  logic              s1_vs;
  logic [11:0]       pal_rgb;

  assign hs_rise  = in_ce & in_hsync & ~hs_prev;
  assign out_tick = (div == DIV_LAST);
  assign we       = in_ce & (hs_rise | (wr_x < LMAX));
  // The pixel carrying the hsync edge opens the new bank at address 0.
  assign wr_addr  = hs_rise ? {~wr_bank, {ADDR_W{1'b0}}} : {wr_bank, wr_x[ADDR_W-1:0]};
  assign rd_addr  = {~wr_bank, rd_x[ADDR_W-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_prev  <= 1'b0;
      wr_x     <= '0;
      wr_bank  <= 1'b0;
      line_len <= '0;
      overflow <= 1'b0;
    end else if (in_ce) begin
      hs_prev <= in_hsync;
      if (hs_rise) begin
        line_len <= wr_x;
        wr_x     <= (ADDR_W + 1)'(1);
        wr_bank  <= ~wr_bank;
      end else if (wr_x < LMAX) begin
        wr_x <= wr_x + 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end
  end

  // Lines captured before the first hsync after reset are partial, so they are never replayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div     <= '0;
      rd_x    <= '0;
      rd_len  <= '0;
      vs_line <= 1'b0;
      synced  <= 1'b0;
    end else if (hs_rise) begin
      div     <= '0;
      rd_x    <= '0;
      rd_len  <= synced ? wr_x : '0;
      vs_line <= in_vsync;
      synced  <= 1'b1;
    end else begin
      div <= out_tick ? '0 : div + 1'b1;
      if (out_tick) begin
        rd_x <= (rd_len == '0 || rd_x == rd_len - 1'b1) ? '0 : rd_x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= in_color;
    if (out_tick) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ce <= 1'b0;
      s1_de <= 1'b0;
      s1_hs <= 1'b0;
      s1_vs <= 1'b0;
    end else begin
      s1_ce <= out_tick;
      if (out_tick) begin
        s1_de <= rd_x < rd_len;
        s1_hs <= rd_x < HS_W;
        s1_vs <= vs_line;
      end
    end
  end

  always_comb begin
    pal_rgb = 12'h000;
    case (rd_data)
      4'h0: pal_rgb = 12'h000;
      4'h1: pal_rgb = 12'hFFF;
      4'h2: pal_rgb = 12'h833;
      4'h3: pal_rgb = 12'h7CC;
      4'h4: pal_rgb = 12'h849;
      4'h5: pal_rgb = 12'h6A5;
      4'h6: pal_rgb = 12'h339;
      4'h7: pal_rgb = 12'hCD7;
      4'h8: pal_rgb = 12'h852;
      4'h9: pal_rgb = 12'h540;
      4'hA: pal_rgb = 12'hB66;
      4'hB: pal_rgb = 12'h444;
      4'hC: pal_rgb = 12'h777;
      4'hD: pal_rgb = 12'hAE9;
      4'hE: pal_rgb = 12'h76C;
      4'hF: pal_rgb = 12'hAAA;
      default: pal_rgb = 12'h000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ce    <= 1'b0;
      out_rgb   <= 12'h000;
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
      out_de    <= 1'b0;
    end else begin
      out_ce    <= s1_ce;
      out_rgb   <= s1_de ? pal_rgb : 12'h000;
      out_hsync <= s1_hs;
      out_vsync <= s1_vs;
      out_de    <= s1_de;
    end
  end

endmodule

// File: tb/tb_vic_scandoubler.sv
// tb/tb_vic_scandoubler.sv - randomized scandoubler bench against a queue-based line model
module tb_vic_scandoubler;

  localparam int LINE_MAX = 512;
  localparam int IN_DIV   = 8;
  localparam int HS_WIDTH = 48;
  localparam int HALF     = IN_DIV / 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_ce = 1'b0;
  logic [3:0]  in_color = 4'h0;
  logic        in_hsync = 1'b0;
  logic        in_vsync = 1'b0;
  logic        out_ce;
  logic [11:0] out_rgb;
  logic        out_hsync;
  logic        out_vsync;
  logic        out_de;
  logic [9:0]  line_len;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [11:0] pal [16] = '{12'h000, 12'hFFF, 12'h833, 12'h7CC, 12'h849, 12'h6A5, 12'h339, 12'hCD7,
                            12'h852, 12'h540, 12'hB66, 12'h444, 12'h777, 12'hAE9, 12'h76C, 12'hAAA};

  // Model: the line being captured, the line being replayed, and the replay position.
  int          edge_n, next_cap, pos, ev_at, exp_len;
  int          cur_line[$];
  int          disp[$];
  bit          ev_pending, synced, m_hs_prev, m_vs, m_ovf;
  bit          ev_de, ev_hs, ev_vs, h_de, h_hs, h_vs;
  logic [11:0] ev_rgb, h_rgb;

  vic_scandoubler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_ce     (in_ce),
    .in_color  (in_color),
    .in_hsync  (in_hsync),
    .in_vsync  (in_vsync),
    .out_ce    (out_ce),
    .out_rgb   (out_rgb),
    .out_hsync (out_hsync),
    .out_vsync (out_vsync),
    .out_de    (out_de),
    .line_len  (line_len),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, act, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    edge_n     = 0;
    next_cap   = HALF;
    pos        = 0;
    ev_pending = 1'b0;
    synced     = 1'b0;
    m_hs_prev  = 1'b0;
    m_vs       = 1'b0;
    m_ovf      = 1'b0;
    exp_len    = 0;
    cur_line.delete();
    disp.delete();
    h_rgb = 12'h000;
    h_de  = 1'b0;
    h_hs  = 1'b0;
    h_vs  = 1'b0;
  endtask

  task automatic step();
    bit rise;
    bit exp_ce;
    @(posedge clk);
    edge_n++;
    if (edge_n == next_cap) begin
      ev_pending = 1'b1;
      ev_at      = edge_n + 1;
      ev_de      = pos < disp.size();
      ev_rgb     = 12'h000;
      if (ev_de) ev_rgb = pal[disp[pos]];
      ev_hs      = pos < HS_WIDTH;
      ev_vs      = m_vs;
      next_cap  += HALF;
      if (disp.size() > 0) pos = (pos + 1) % disp.size();
    end
    if (in_ce) begin
      rise      = in_hsync && !m_hs_prev;
      m_hs_prev = in_hsync;
      if (rise) begin
        exp_len = cur_line.size();
        if (synced) disp = cur_line;
        else disp.delete();
        cur_line.delete();
        cur_line.push_back(int'(in_color));
        synced   = 1'b1;
        m_vs     = in_vsync;
        pos      = 0;
        next_cap = edge_n + HALF;
      end else if (cur_line.size() < LINE_MAX) begin
        cur_line.push_back(int'(in_color));
      end else begin
        m_ovf = 1'b1;
      end
    end
    #1;
    exp_ce = ev_pending && (ev_at == edge_n);
    if (exp_ce) begin
      h_rgb      = ev_rgb;
      h_de       = ev_de;
      h_hs       = ev_hs;
      h_vs       = ev_vs;
      ev_pending = 1'b0;
    end
    check("out_ce",    32'(out_ce),    32'(exp_ce));
    check("out_rgb",   32'(out_rgb),   32'(h_rgb));
    check("out_de",    32'(out_de),    32'(h_de));
    check("out_hsync", 32'(out_hsync), 32'(h_hs));
    check("out_vsync", 32'(out_vsync), 32'(h_vs));
    check("line_len",  32'(line_len),  32'(exp_len));
    check("overflow",  32'(overflow),  32'(m_ovf));
  endtask

  task automatic drive_px(input logic [3:0] c, input bit hs, input bit vs);
    in_ce    = 1'b1;
    in_color = c;
    in_hsync = hs;
    in_vsync = vs;
    step();
    in_ce = 1'b0;
    for (int i = 0; i < IN_DIV - 1; i++) begin
      in_color = 4'($urandom);
      step();
    end
  endtask

  task automatic run_line(input int len, input bit vs, input bit rnd, input int first_px);
    logic [3:0] c;
    for (int px = first_px; px < len; px++) begin
      c = rnd ? 4'($urandom) : px[3:0];
      drive_px(c, px < 4, vs);
    end
  endtask

  task automatic do_reset(input int ncyc);
    in_ce    = 1'b0;
    in_hsync = 1'b0;
    in_vsync = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_ce",    32'(out_ce),    32'd0);
    check("rst_out_rgb",   32'(out_rgb),   32'd0);
    check("rst_out_de",    32'(out_de),    32'd0);
    check("rst_out_hsync", 32'(out_hsync), 32'd0);
    check("rst_out_vsync", 32'(out_vsync), 32'd0);
    check("rst_line_len",  32'(line_len),  32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("init_out_rgb",  32'(out_rgb),  32'd0);
    check("init_out_de",   32'(out_de),   32'd0);
    check("init_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Idle: free-running output strobe, blank output.
    for (int i = 0; i < 40; i++) step();

    // Fixed 400-pixel lines with colour = x[3:0].
    for (int l = 0; l < 4; l++) run_line(400, 1'b0, 1'b0, 0);
    check("line_len_400", 32'(line_len), 32'd400);

    // Oversized line, then shorter lines: overflow stays set.
    run_line(600, 1'b0, 1'b1, 0);
    run_line(300, 1'b0, 1'b1, 0);
    check("line_len_512", 32'(line_len), 32'd512);
    run_line(300, 1'b0, 1'b1, 0);
    check("line_len_300", 32'(line_len), 32'd300);
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Random lengths (hsync lands mid-replay), vsync on lines 10..12.
    for (int l = 0; l < 15; l++) run_line(int'($urandom_range(300, 20)), (l >= 10) && (l <= 12), 1'b1, 0);

    // Reset in the middle of a line, then resume without hsync.
    run_line(100, 1'b0, 1'b1, 0);
    do_reset(3);
    run_line(250, 1'b0, 1'b1, 100);
    for (int l = 0; l < 3; l++) run_line(int'($urandom_range(260, 60)), 1'b0, 1'b1, 0);
    check("post_reset_overflow", 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
